reg_select_decoder: RTL and testbench

- Parametrised, registered binary-to-one-hot register-select decoder for the register-file write path.
- Generalises the fixed 2-to-4 select to SEL_W address bits and NUM_OUT outputs. NUM_OUT need not be a power of two.
- Adds enable, out-of-range error detection, and a SCAN mode that walks a single hot bit across every output. SCAN is used for register-file clear/initialisation sequences.

---
 rtl/reg_select_decoder_if.sv | 25 ++
 rtl/reg_select_decoder.sv | 135 +++++++++++++
 tb/tb_reg_select_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_select_decoder_if.sv
// Signal bundle between a register-file controller and the select decoder.
// The controller drives the request side; the decoder drives the select side.
interface reg_select_decoder_if #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
);
    logic               en;
    logic [SEL_W-1:0]   reg_no;
    logic               scan_start;
    logic [NUM_OUT-1:0] register;
    logic               valid;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output en, reg_no, scan_start,
        input  register, valid, busy, done, err
    );

    modport slave (
        input  en, reg_no, scan_start,
        output register, valid, busy, done, err
    );
endinterface

// File: rtl/reg_select_decoder.sv
// Registered binary-to-one-hot register-select decoder with range check and walking-one SCAN.
// Optional macro REG_SELECT_HOLD_EN: hold the last select in IDLE while en=0 instead of clearing.
module reg_select_decoder #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_select_decoder_if.slave  bus
);

    generate
        if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_params
            $error("reg_select_decoder: NUM_OUT must be in 2..2**SEL_W");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // One extra bit so NUM_OUT == 2**SEL_W compares correctly against reg_no.
    localparam logic [SEL_W:0]     NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);
    localparam logic [SEL_W-1:0]   LAST_IDX    = SEL_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] FIRST_HOT   = NUM_OUT'(1);

    state_t             r_state, w_state_next;
    logic [SEL_W-1:0]   r_idx, w_idx_next;
    logic [NUM_OUT-1:0] r_register, w_register_next;
    logic               r_valid, w_valid_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;
    logic               r_err, w_err_next;

    logic               w_in_range;
    logic [NUM_OUT-1:0] w_decoded;

    assign w_in_range = ({1'b0, bus.reg_no} < NUM_OUT_EXT);

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_decode
            localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);
            assign w_decoded[gi] = (bus.reg_no == IDX);
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_register_next = r_register;
        w_valid_next    = r_valid;
        w_busy_next     = 1'b0;
        w_done_next     = 1'b0;
        w_err_next      = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.scan_start) begin
                    w_register_next = FIRST_HOT;
                    w_valid_next    = 1'b1;
                    w_busy_next     = 1'b1;
                    w_idx_next      = '0;
                    w_state_next    = SCAN;
                end else if (bus.en) begin
                    if (w_in_range) begin
                        w_register_next = w_decoded;
                        w_valid_next    = 1'b1;
                    end else begin
                        w_register_next = '0;
                        w_valid_next    = 1'b0;
                        w_err_next      = 1'b1;
                    end
                end else begin
`ifdef REG_SELECT_HOLD_EN
                    w_register_next = r_register;
                    w_valid_next    = r_valid;
`else
                    w_register_next = '0;
                    w_valid_next    = 1'b0;
`endif
                end
            end

            SCAN: begin
                if (r_idx == LAST_IDX) begin
                    w_register_next = '0;
                    w_valid_next    = 1'b0;
                    w_done_next     = 1'b1;
                    w_idx_next      = '0;
                    w_state_next    = IDLE;
                end else begin
                    w_register_next = {r_register[NUM_OUT-2:0], 1'b0};
                    w_valid_next    = 1'b1;
                    w_busy_next     = 1'b1;
                    w_idx_next      = r_idx + SEL_W'(1);
                end
            end

            default: begin
                w_register_next = '0;
                w_valid_next    = 1'b0;
                w_idx_next      = '0;
                w_state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_register <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_register <= w_register_next;
            r_valid    <= w_valid_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
        end
    end

    assign bus.register = r_register;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_reg_select_decoder.sv
// Scoreboard bench: dut_a uses default parameters (2,4), dut_b uses SEL_W=2, NUM_OUT=3.
module tb_reg_select_decoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_select_decoder_if #(.SEL_W(2), .NUM_OUT(4)) bus_a ();
    reg_select_decoder_if #(.SEL_W(2), .NUM_OUT(3)) bus_b ();

    reg_select_decoder #(.SEL_W(2), .NUM_OUT(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    reg_select_decoder #(.SEL_W(2), .NUM_OUT(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // {register (zero-padded to 4 bits), valid, busy, done, err}
    typedef struct packed {
        logic [3:0] sel;
        logic       valid;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t mk(input logic [3:0] s, input logic v, input logic b,
                                input logic d, input logic e);
        return {s, v, b, d, e};
    endfunction

    function automatic obs_t obs_a();
        return {bus_a.register, bus_a.valid, bus_a.busy, bus_a.done, bus_a.err};
    endfunction

    function automatic obs_t obs_b();
        return {1'b0, bus_b.register, bus_b.valid, bus_b.busy, bus_b.done, bus_b.err};
    endfunction

    task automatic drive_a(input logic s, input logic e, input logic [1:0] r);
        bus_a.scan_start = s;
        bus_a.en         = e;
        bus_a.reg_no     = r;
    endtask

    task automatic drive_b(input logic s, input logic e, input logic [1:0] r);
        bus_b.scan_start = s;
        bus_b.en         = e;
        bus_b.reg_no     = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        rst_n = 1'b0;
        drive_a(1'b1, 1'b1, 2'd3);
        drive_b(1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                rst_n = 1'b1;
                drive_a(1'b0, 1'b0, 2'd0);
                drive_b(1'b0, 1'b0, 2'd0);
            end
            exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_a step %0d: got %b required %b", i, g, e);
            end
            e = exp_q.pop_front(); g = obs_b(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_b step %0d: got %b required %b", i, g, e);
            end
        end
    endtask

    task automatic test_decode();
        obs_t e, g;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drive_a(1'b0, 1'b1, 2'(i));
                exp_q.push_back(mk(4'(1 << i), 1'b1, 1'b0, 1'b0, 1'b0));
            end else begin
                drive_a(1'b0, 1'b0, 2'd1);
`ifdef REG_SELECT_HOLD_EN
                exp_q.push_back(mk(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0));
`else
                exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
            end
            tick();
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL decode step %0d: got %b required %b", i, g, e);
            end
        end
    endtask

    task automatic test_out_of_range();
        obs_t e, g;
        logic [1:0] rn [4] = '{2'd3, 2'd2, 2'd3, 2'd0};
        logic       en [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] s  [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
        logic       v  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       er [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b0, en[i], rn[i]);
            exp_q.push_back(mk(s[i], v[i], 1'b0, 1'b0, er[i]));
            tick();
            e = exp_q.pop_front(); g = obs_b(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL out_of_range step %0d: got %b required %b", i, g, e);
            end
        end
    endtask

    task automatic test_scan();
        obs_t e, g;
        for (int i = 0; i < 6; i++) begin
            // A second scan_start mid-scan must be ignored; en is held throughout.
            drive_a((i == 0) || (i == 2), 1'b1, 2'd0);
            if (i < 4)       exp_q.push_back(mk(4'(1 << i), 1'b1, 1'b1, 1'b0, 1'b0));
            else if (i == 4) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));
            else             exp_q.push_back(mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL scan step %0d: got %b required %b", i, g, e);
            end
        end
        drive_a(1'b0, 1'b0, 2'd0);
        tick();
    endtask

    task automatic test_simultaneous();
        obs_t e, g;
        for (int i = 0; i < 5; i++) begin
            if (i < 3)  drive_b(i == 0, 1'b1, 2'd3);
            else        drive_b(1'b0, 1'b0, 2'd0);
            if (i < 3)       exp_q.push_back(mk(4'(1 << i), 1'b1, 1'b1, 1'b0, 1'b0));
            else if (i == 3) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));
            else             exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front(); g = obs_b(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL simultaneous step %0d: got %b required %b", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        for (int i = 0; i < 11; i++) begin
            drive_a((i == 0) || (i == 5), 1'b0, 2'd0);
            if (i == 4 || i == 9)  exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));
            else if (i == 10)      exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
            else                   exp_q.push_back(mk(4'(1 << (i % 5)), 1'b1, 1'b1, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b required %b", i, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        obs_t e, g;
        for (int i = 0; i < 10; i++) begin
            rst_n = (i != 3);
            drive_a((i == 0) || (i == 3) || (i == 4), i == 3, 2'd1);
            if (i < 3)       exp_q.push_back(mk(4'(1 << i), 1'b1, 1'b1, 1'b0, 1'b0));
            else if (i == 3) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
            else if (i < 8)  exp_q.push_back(mk(4'(1 << (i - 4)), 1'b1, 1'b1, 1'b0, 1'b0));
            else if (i == 8) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));
            else             exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front(); g = obs_a(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid_scan step %0d: got %b required %b", i, g, e);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_hold();
        obs_t e, g;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      drive_b(1'b0, 1'b1, 2'd2);
            else if (i == 4) drive_b(1'b0, 1'b1, 2'd3);
            else             drive_b(1'b0, 1'b0, 2'd1);
            if (i == 0) exp_q.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0));
            else if (i < 4) begin
`ifdef REG_SELECT_HOLD_EN
                exp_q.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0));
`else
                exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
            end
            else if (i == 4) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1));
            else             exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front(); g = obs_b(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL hold step %0d: got %b required %b", i, g, e);
            end
        end
    endtask

    initial begin
        drive_a(1'b0, 1'b0, 2'd0);
        drive_b(1'b0, 1'b0, 2'd0);
        rst_n = 1'b0;
        #2;
        test_reset();
        test_decode();
        test_out_of_range();
        test_scan();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_scan();
        test_hold();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
